// File: rtl/sblk_skew_ctrl_if.sv
// sblk_skew_ctrl_if: bundle between superblock controller, skew ctrl, columns.
// master: controller + column units side; slave: sblk_skew_ctrl.
interface sblk_skew_ctrl_if #(
  parameter int N_COLUMN     = 4,
  parameter int WID_CTRL     = 48,
  parameter int WID_DIN      = 32,
  parameter int WID_PSUMADDR = 9,
  parameter int WID_DOUT     = 64
);
  logic                             cfg_mode;
  logic [N_COLUMN-1:0]              cfg_col_en;
  logic [WID_CTRL-1:0]              ctrl_in;
  logic [WID_DIN-1:0]               din;
  logic                             din_vld;
  logic [N_COLUMN*WID_CTRL-1:0]     col_ctrl;
  logic [N_COLUMN*WID_DIN-1:0]      col_din;
  logic [N_COLUMN-1:0]              col_din_vld;
  logic                             rd_req_vld;
  logic [WID_PSUMADDR-1:0]          rd_req_addr;
  logic                             rd_req_rdy;
  logic [N_COLUMN-1:0]              col_rd_en;
  logic [N_COLUMN*WID_PSUMADDR-1:0] col_rd_addr;
  logic [N_COLUMN*WID_DOUT-1:0]     col_rd_data;
  logic [N_COLUMN*WID_DOUT-1:0]     psum_out;
  logic                             psum_out_vld;
  logic                             psum_out_rdy;
  logic                             busy;

  modport master (
    output cfg_mode, cfg_col_en, ctrl_in, din, din_vld,
    output rd_req_vld, rd_req_addr, col_rd_data, psum_out_rdy,
    input  col_ctrl, col_din, col_din_vld, rd_req_rdy,
    input  col_rd_en, col_rd_addr, psum_out, psum_out_vld, busy
  );

  modport slave (
    input  cfg_mode, cfg_col_en, ctrl_in, din, din_vld,
    input  rd_req_vld, rd_req_addr, col_rd_data, psum_out_rdy,
    output col_ctrl, col_din, col_din_vld, rd_req_rdy,
    output col_rd_en, col_rd_addr, psum_out, psum_out_vld, busy
  );
endinterface

// File: rtl/sblk_skew_ctrl.sv
// sblk_skew_ctrl: systolic/broadcast skew of ctrl+data to N_COLUMN columns,
// de-skew of psum reads into a credited output FIFO.
// Ports: clk_l, rst_n (async low), bus (slave: cfg, fwd, rd req,
// column side, psum_out handshake, busy). Requires N_COLUMN >= 2.
module sblk_skew_ctrl #(
  parameter int N_COLUMN     = 4,
  parameter int STAGE        = 1,
  parameter int WID_CTRL     = 48,
  parameter int WID_DIN      = 32,
  parameter int WID_PSUMADDR = 9,
  parameter int WID_DOUT     = 64,
  parameter int RD_LAT       = 2,
  parameter int FIFO_DEPTH   = 8
) (
  input logic             clk_l,
  input logic             rst_n,
  sblk_skew_ctrl_if.slave bus
);
  localparam int DS = (N_COLUMN - 1) * STAGE;
  localparam int TL = DS + RD_LAT;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int WW = N_COLUMN * WID_DOUT;

  logic                    mode_q, mode_d;
  logic [N_COLUMN-1:0]     col_en_q, col_en_d;
  logic [WID_CTRL-1:0]     ctl_q [1:DS];
  logic [WID_CTRL-1:0]     ctl_d [1:DS];
  logic [WID_DIN-1:0]      din_q [1:DS];
  logic [WID_DIN-1:0]      din_d [1:DS];
  logic [WID_PSUMADDR-1:0] ra_q [1:DS];
  logic [WID_PSUMADDR-1:0] ra_d [1:DS];
  logic [DS:1]             dv_q, dv_d;
  logic [DS:1]             re_q, re_d;
  logic [TL:1]             tag_q, tag_d;
  logic [WW-1:0]           mem_q [FIFO_DEPTH];
  logic [WW-1:0]           mem_d [FIFO_DEPTH];
  logic [PW-1:0]           wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [CW-1:0]           infl_q, infl_d;

  logic [WID_CTRL-1:0]     ctl_t [0:DS];
  logic [WID_DIN-1:0]      din_t [0:DS];
  logic [WID_PSUMADDR-1:0] ra_t [0:DS];
  logic [DS:0]             dv_t, re_t;
  logic [TL:0]             tag_t;
  logic [WW-1:0]           aln;
  logic                    busy, rdy, acc, push, pop;

  always_comb begin
    busy = (infl_q != '0) | (cnt_q != '0) | (|dv_q);
    rdy  = ({1'b0, cnt_q} + {1'b0, infl_q})
           < (CW+1)'(FIFO_DEPTH);
    acc  = bus.rd_req_vld & rdy;
    pop  = (cnt_q != '0) & bus.psum_out_rdy;

    ctl_t[0] = bus.ctrl_in;
    din_t[0] = bus.din;
    ra_t[0]  = bus.rd_req_addr;
    for (int k = 1; k <= DS; k++) begin
      ctl_t[k] = ctl_q[k];
      din_t[k] = din_q[k];
      ra_t[k]  = ra_q[k];
    end
    // Broadcast never uses the skew chain; keeping it empty
    // lets busy drop as soon as nothing is really in flight.
    dv_t  = {dv_q, bus.din_vld & ~mode_q};
    re_t  = {re_q, acc};
    tag_t = {tag_q, acc};
    push  = mode_q ? tag_t[RD_LAT] : tag_t[TL];

    for (int k = 1; k <= DS; k++) begin
      ctl_d[k] = ctl_t[k-1];
      din_d[k] = din_t[k-1];
      ra_d[k]  = ra_t[k-1];
    end
    dv_d  = dv_t[DS-1:0];
    re_d  = re_t[DS-1:0];
    tag_d = tag_t[TL-1:0];

    mode_d   = busy ? mode_q : bus.cfg_mode;
    col_en_d = busy ? col_en_q : bus.cfg_col_en;

    mem_d = mem_q;
    if (push) mem_d[wp_q] = aln;
    wp_d   = wp_q + PW'(push);
    rp_d   = rp_q + PW'(pop);
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    infl_d = infl_q + CW'(acc) - CW'(push);
  end

  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= 1'b0;
      col_en_q <= '1;
      for (int k = 1; k <= DS; k++) begin
        ctl_q[k] <= '0;
        din_q[k] <= '0;
        ra_q[k]  <= '0;
      end
      dv_q  <= '0;
      re_q  <= '0;
      tag_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem_q[i] <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      infl_q <= '0;
    end else begin
      mode_q   <= mode_d;
      col_en_q <= col_en_d;
      ctl_q    <= ctl_d;
      din_q    <= din_d;
      ra_q     <= ra_d;
      dv_q     <= dv_d;
      re_q     <= re_d;
      tag_q    <= tag_d;
      mem_q    <= mem_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      cnt_q    <= cnt_d;
      infl_q   <= infl_d;
    end
  end

  for (genvar c = 0; c < N_COLUMN; c++) begin : g_col
    localparam int DC = c * STAGE;
    localparam int LC = DS - DC;
    logic [WID_DOUT-1:0] rin;

    assign bus.col_ctrl[c*WID_CTRL +: WID_CTRL] =
      mode_q ? ctl_t[0] : ctl_t[DC];
    assign bus.col_din[c*WID_DIN +: WID_DIN] =
      mode_q ? din_t[0] : din_t[DC];
    assign bus.col_din_vld[c] =
      (mode_q ? bus.din_vld : dv_t[DC]) & col_en_q[c];
    assign bus.col_rd_en[c] =
      (mode_q ? re_t[0] : re_t[DC]) & col_en_q[c];
    assign bus.col_rd_addr[c*WID_PSUMADDR +: WID_PSUMADDR] =
      mode_q ? ra_t[0] : ra_t[DC];

    assign rin = bus.col_rd_data[c*WID_DOUT +: WID_DOUT]
                 & {WID_DOUT{col_en_q[c]}};

    // Early columns wait for the last one: extra D_max-d_c stages.
    if (LC > 0) begin : g_dly
      logic [WID_DOUT-1:0] rdl_q [1:LC];
      logic [WID_DOUT-1:0] rdl_d [1:LC];

      always_comb begin
        rdl_d[1] = rin;
        for (int k = 2; k <= LC; k++)
          rdl_d[k] = rdl_q[k-1];
      end

      always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 1; k <= LC; k++)
            rdl_q[k] <= '0;
        end else begin
          rdl_q <= rdl_d;
        end
      end

      assign aln[c*WID_DOUT +: WID_DOUT] =
        mode_q ? rin : rdl_q[LC];
    end else begin : g_nodly
      assign aln[c*WID_DOUT +: WID_DOUT] = rin;
    end
  end

  assign bus.rd_req_rdy   = rdy;
  assign bus.psum_out     = mem_q[rp_q];
  assign bus.psum_out_vld = cnt_q != '0;
  assign bus.busy         = busy;
endmodule

// File: tb/tb_sblk_skew_ctrl.sv
// tb_sblk_skew_ctrl: directed bench for sblk_skew_ctrl with
// RD_LAT=2 column read models returning {addr, 0x1000+c}.
module tb_sblk_skew_ctrl;
  localparam int N  = 4;
  localparam int WC = 48;
  localparam int WD = 32;
  localparam int WA = 9;
  localparam int WO = 64;

  logic clk_l = 1'b0;
  logic rst_n = 1'b0;
  int   nvec  = 0;
  int   nmis  = 0;
  logic [3:0] e4, bad;
  logic       stale;

  always #5 clk_l = ~clk_l;

  sblk_skew_ctrl_if #(
    .N_COLUMN(N), .WID_CTRL(WC), .WID_DIN(WD),
    .WID_PSUMADDR(WA), .WID_DOUT(WO)
  ) bus ();

  sblk_skew_ctrl #(
    .N_COLUMN(N), .STAGE(1), .WID_CTRL(WC), .WID_DIN(WD),
    .WID_PSUMADDR(WA), .WID_DOUT(WO), .RD_LAT(2), .FIFO_DEPTH(8)
  ) dut (
    .clk_l(clk_l),
    .rst_n(rst_n),
    .bus(bus)
  );

  function automatic logic [63:0] mword(logic [8:0] a, int c);
    return {39'd0, a, 16'h1000 + 16'(c)};
  endfunction

  function automatic logic [255:0] exp_word(logic [8:0] a,
                                            logic [3:0] en);
    logic [255:0] w = '0;
    for (int c = 0; c < N; c++)
      if (en[c]) w[c*WO +: WO] = mword(a, c);
    return w;
  endfunction

  // Column read models: two-cycle read latency.
  logic [N-1:0]  m_en1, m_en2;
  logic [WA-1:0] m_a1 [N];
  logic [WA-1:0] m_a2 [N];

  always @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      m_en1 <= '0;
      m_en2 <= '0;
      for (int c = 0; c < N; c++) begin
        m_a1[c] <= '0;
        m_a2[c] <= '0;
      end
    end else begin
      m_en1 <= bus.col_rd_en;
      m_en2 <= m_en1;
      for (int c = 0; c < N; c++) begin
        m_a1[c] <= bus.col_rd_addr[c*WA +: WA];
        m_a2[c] <= m_a1[c];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < N; c++)
      bus.col_rd_data[c*WO +: WO] = m_en2[c] ? mword(m_a2[c], c)
                                  : {48'hDEAD_BEEF_0000, 16'(c)};
  end

  task automatic chk1(input string tag, input logic o, input logic e);
    nvec++;
    assert (o === e) else begin
      nmis++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic chkn(input string tag, input logic [31:0] o,
                      input logic [31:0] e);
    nvec++;
    assert (o === e) else begin
      nmis++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic chkw(input string tag, input logic [255:0] o,
                      input logic [255:0] e);
    nvec++;
    assert (o === e) else begin
      nmis++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic cyc();
    @(posedge clk_l);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_l);
  endtask

  task automatic zero_in();
    bus.ctrl_in     = '0;
    bus.din         = '0;
    bus.din_vld     = 1'b0;
    bus.rd_req_vld  = 1'b0;
    bus.rd_req_addr = '0;
  endtask

  task automatic idle(input int n);
    zero_in();
    repeat (n) cyc();
  endtask

  // One read at cycle 0; word expected exactly at cycle lat.
  task automatic rd_one(input logic m, input int lat,
                        input logic [8:0] a);
    bus.cfg_mode = m;
    idle(3);
    bus.rd_req_vld  = 1'b1;
    bus.rd_req_addr = a;
    smp();
    chk1("rd_rdy", bus.rd_req_rdy, 1'b1);
    chkn("rd_en0", 32'(bus.col_rd_en), m ? 32'hF : 32'h1);
    cyc();
    zero_in();
    for (int k = 1; k <= lat; k++) begin
      smp();
      if (k == lat) begin
        chk1("rd_vld", bus.psum_out_vld, 1'b1);
        chkw("rd_word", bus.psum_out, exp_word(a, 4'hF));
      end else if (k == lat - 1) begin
        chk1("rd_early", bus.psum_out_vld, 1'b0);
      end
      cyc();
    end
    smp();
    chk1("rd_popped", bus.psum_out_vld, 1'b0);
    cyc();
  endtask

  initial begin
    bus.cfg_mode     = 1'b0;
    bus.cfg_col_en   = 4'hF;
    bus.psum_out_rdy = 1'b1;
    zero_in();

    // Reset state
    repeat (2) @(posedge clk_l);
    smp();
    chk1("rst_vld", bus.psum_out_vld, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chkw("rst_psum", bus.psum_out, 256'd0);
    cyc();
    rst_n = 1'b1;
    smp();
    chk1("rel_rdy", bus.rd_req_rdy, 1'b1);
    chkn("rel_dvld", 32'(bus.col_din_vld), 32'h0);
    chkn("rel_rden", 32'(bus.col_rd_en), 32'h0);
    cyc();

    // Forward skew, systolic
    idle(2);
    for (int k = 0; k < 5; k++) begin
      if (k == 0) begin
        bus.din     = 32'hA5;
        bus.din_vld = 1'b1;
        bus.ctrl_in = 48'h0123_4567_89AB;
      end else begin
        zero_in();
      end
      smp();
      e4 = (k < 4) ? 4'(1 << k) : 4'h0;
      chkn("fwd_vld", 32'(bus.col_din_vld), 32'(e4));
      chk1("fwd_busy", bus.busy, (k >= 1) && (k <= 3));
      if (k < 4) begin
        chkn("fwd_din", bus.col_din[k*WD +: WD], 32'hA5);
        chkw("fwd_ctl", 256'(bus.col_ctrl[k*WC +: WC]),
             256'(48'h0123_4567_89AB));
      end
      cyc();
    end

    // Forward, broadcast
    bus.cfg_mode = 1'b1;
    idle(2);
    bus.din     = 32'hA5;
    bus.din_vld = 1'b1;
    smp();
    chkn("bc_vld", 32'(bus.col_din_vld), 32'hF);
    for (int c = 0; c < N; c++)
      chkn("bc_din", bus.col_din[c*WD +: WD], 32'hA5);
    cyc();
    zero_in();
    smp();
    chkn("bc_vld_off", 32'(bus.col_din_vld), 32'h0);
    cyc();

    // Read alignment
    rd_one(1'b0, 6, 9'h000);
    rd_one(1'b1, 3, 9'h000);
    rd_one(1'b0, 6, 9'h1A5);

    // Backpressure
    bus.psum_out_rdy = 1'b0;
    rd_one_skip: begin end
    bus.cfg_mode = 1'b0;
    idle(3);
    for (int k = 0; k < 10; k++) begin
      bus.rd_req_vld  = 1'b1;
      bus.rd_req_addr = 9'(9'h100 + k);
      smp();
      chk1("bp_rdy", bus.rd_req_rdy, k < 8);
      cyc();
    end
    zero_in();
    smp();
    chk1("bp_rdy_low", bus.rd_req_rdy, 1'b0);
    idle(6);
    smp();
    chk1("bp_full_vld", bus.psum_out_vld, 1'b1);
    chk1("bp_full_rdy", bus.rd_req_rdy, 1'b0);
    cyc();
    bus.psum_out_rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      smp();
      chk1("bp_pop_vld", bus.psum_out_vld, 1'b1);
      chkw("bp_pop_word", bus.psum_out,
           exp_word(9'(9'h100 + k), 4'hF));
      cyc();
    end
    smp();
    chk1("bp_empty", bus.psum_out_vld, 1'b0);
    chk1("bp_rdy_back", bus.rd_req_rdy, 1'b1);
    cyc();

    // Column mask
    bus.cfg_col_en = 4'b0101;
    idle(3);
    bad = '0;
    for (int k = 0; k < 7; k++) begin
      if (k == 0) begin
        bus.din         = 32'h5A;
        bus.din_vld     = 1'b1;
        bus.rd_req_vld  = 1'b1;
        bus.rd_req_addr = 9'h055;
      end else begin
        zero_in();
      end
      smp();
      bad = bad | ((bus.col_din_vld | bus.col_rd_en) & 4'b1010);
      if (k == 2)
        chkn("mask_vld2", 32'(bus.col_din_vld), 32'h4);
      if (k == 6) begin
        chk1("mask_vld", bus.psum_out_vld, 1'b1);
        chkw("mask_word", bus.psum_out, exp_word(9'h055, 4'b0101));
      end
      cyc();
    end
    chkn("mask_never", 32'(bad), 32'h0);
    bus.cfg_col_en = 4'hF;
    idle(3);

    // Config change while busy
    bus.cfg_mode = 1'b0;
    idle(3);
    for (int k = 0; k < 7; k++) begin
      if (k == 0) begin
        bus.rd_req_vld  = 1'b1;
        bus.rd_req_addr = 9'h0C3;
      end else begin
        zero_in();
      end
      if (k == 1) bus.cfg_mode = 1'b1;
      smp();
      if (k == 2)
        chkn("cfgb_rden2", 32'(bus.col_rd_en), 32'h4);
      if (k == 3)
        chk1("cfgb_no3", bus.psum_out_vld, 1'b0);
      if (k == 6) begin
        chk1("cfgb_vld6", bus.psum_out_vld, 1'b1);
        chkw("cfgb_word", bus.psum_out, exp_word(9'h0C3, 4'hF));
      end
      cyc();
    end
    rd_one(1'b1, 3, 9'h03C);

    // Reset mid-operation: 3 in flight, 2 queued
    bus.cfg_mode     = 1'b0;
    bus.psum_out_rdy = 1'b0;
    idle(3);
    for (int k = 0; k < 5; k++) begin
      bus.rd_req_vld  = 1'b1;
      bus.rd_req_addr = 9'(9'h1E0 + k);
      smp();
      cyc();
    end
    zero_in();
    cyc();
    cyc();
    chk1("pre_rst_vld", bus.psum_out_vld, 1'b1);
    chk1("pre_rst_busy", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_vld", bus.psum_out_vld, 1'b0);
    chk1("mid_rst_busy", bus.busy, 1'b0);
    chkn("mid_rst_dvld", 32'(bus.col_din_vld), 32'h0);
    chkn("mid_rst_rden", 32'(bus.col_rd_en), 32'h0);
    chkn("mid_rst_addr", 32'(bus.col_rd_addr), 32'h0);
    chkw("mid_rst_din", 256'(bus.col_din), 256'd0);
    chkw("mid_rst_ctl", 256'(bus.col_ctrl), 256'd0);
    chkw("mid_rst_psum", bus.psum_out, 256'd0);
    cyc();
    rst_n = 1'b1;
    bus.psum_out_rdy = 1'b1;
    stale = 1'b0;
    for (int k = 0; k < 12; k++) begin
      smp();
      stale = stale | bus.psum_out_vld;
      cyc();
    end
    chk1("no_stale", stale, 1'b0);
    chk1("post_rst_rdy", bus.rd_req_rdy, 1'b1);
    chk1("post_rst_busy", bus.busy, 1'b0);
    rd_one(1'b0, 6, 9'h0AA);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
